// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types used by the cache hierarchy.
package lc3b_types;
    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_cacheline;
endpackage

// File: rtl/arb_priority_picker.sv
// Combinational winner selection: fixed priority (RR_MODE=0) or round-robin
// starting just after the last completed grant (RR_MODE=1).
module arb_priority_picker #(
    parameter int NUM_CH  = 2,
    parameter int RR_MODE = 0
) (
    input  logic [NUM_CH-1:0]         req,
    input  logic [$clog2(NUM_CH)-1:0] last,
    output logic [$clog2(NUM_CH)-1:0] idx
);
    localparam int IDX_W = $clog2(NUM_CH);

    int               base;
    logic [IDX_W-1:0] cand;

    // Scan from the farthest candidate down so the nearest requester is
    // the final assignment and therefore wins.
    always_comb begin
        base = (RR_MODE != 0) ? int'(last) + 1 : 0;
        cand = '0;
        idx  = '0;
        for (int off = NUM_CH - 1; off >= 0; off--) begin
            cand = IDX_W'((base + off) % NUM_CH);
            if (req[cand]) idx = cand;
        end
    end
endmodule

// File: rtl/cacheline_arbiter.sv
// Arbitrates NUM_CH cacheline requesters onto one downstream port; one
// transaction at a time, with a one-cycle gap after each completion.
module cacheline_arbiter
    import lc3b_types::*;
#(
    parameter int NUM_CH  = 2,
    parameter int RR_MODE = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            m_read,
    input  logic [NUM_CH-1:0]            m_write,
    input  lc3b_word      [NUM_CH-1:0]   m_address,
    input  lc3b_cacheline [NUM_CH-1:0]   m_wdata,
    output logic [NUM_CH-1:0]            m_resp,
    output lc3b_cacheline [NUM_CH-1:0]   m_rdata,
    output logic                         s_read,
    output logic                         s_write,
    output lc3b_word                     s_address,
    output lc3b_cacheline                s_wdata,
    input  logic                         s_resp,
    input  lc3b_cacheline                s_rdata
);
    localparam int IDX_W = $clog2(NUM_CH);

    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

    state_t           state, state_d;
    logic [IDX_W-1:0] grant, grant_d;
    logic [IDX_W-1:0] last, last_d;
    logic [IDX_W-1:0] pick_idx;
    logic [NUM_CH-1:0] req;

    assign req     = m_read | m_write;
    assign m_rdata = {NUM_CH{s_rdata}};

    arb_priority_picker #(
        .NUM_CH  (NUM_CH),
        .RR_MODE (RR_MODE)
    ) u_picker (
        .req  (req),
        .last (last),
        .idx  (pick_idx)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= '0;
            last  <= IDX_W'(NUM_CH - 1);
        end else begin
            state <= state_d;
            grant <= grant_d;
            last  <= last_d;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state;
        grant_d   = grant;
        last_d    = last;
        m_resp    = '0;
        s_read    = 1'b0;
        s_write   = 1'b0;
        s_address = '0;
        s_wdata   = '0;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    grant_d = pick_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // A simultaneous read and write is served as a write.
                s_write   = m_write[grant];
                s_read    = m_read[grant] & ~m_write[grant];
                s_address = m_address[grant];
                s_wdata   = m_wdata[grant];
                if (s_resp) begin
                    m_resp[grant] = 1'b1;
                    last_d        = grant;
                    state_d       = GAP;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cacheline_arbiter.sv
// Self-checking bench: a 2-channel fixed-priority and a 4-channel round-robin
// arbiter, served by a scoreboard-driven downstream responder.
module tb_cacheline_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: NUM_CH=2, fixed priority.
    logic [1:0]         a_m_read, a_m_write, a_m_resp;
    logic [1:0][15:0]   a_m_address;
    logic [1:0][127:0]  a_m_wdata, a_m_rdata;
    logic               a_s_read, a_s_write, a_s_resp;
    logic [15:0]        a_s_address;
    logic [127:0]       a_s_wdata, a_s_rdata;

    // Instance B: NUM_CH=4, round-robin.
    logic [3:0]         b_m_read, b_m_write, b_m_resp;
    logic [3:0][15:0]   b_m_address;
    logic [3:0][127:0]  b_m_wdata, b_m_rdata;
    logic               b_s_read, b_s_write, b_s_resp;
    logic [15:0]        b_s_address;
    logic [127:0]       b_s_wdata, b_s_rdata;

    cacheline_arbiter #(.NUM_CH(2), .RR_MODE(0)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .m_read(a_m_read), .m_write(a_m_write), .m_address(a_m_address),
        .m_wdata(a_m_wdata), .m_resp(a_m_resp), .m_rdata(a_m_rdata),
        .s_read(a_s_read), .s_write(a_s_write), .s_address(a_s_address),
        .s_wdata(a_s_wdata), .s_resp(a_s_resp), .s_rdata(a_s_rdata)
    );

    cacheline_arbiter #(.NUM_CH(4), .RR_MODE(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .m_read(b_m_read), .m_write(b_m_write), .m_address(b_m_address),
        .m_wdata(b_m_wdata), .m_resp(b_m_resp), .m_rdata(b_m_rdata),
        .s_read(b_s_read), .s_write(b_s_write), .s_address(b_s_address),
        .s_wdata(b_s_wdata), .s_resp(b_s_resp), .s_rdata(b_s_rdata)
    );

    typedef struct {
        int           ch;
        logic [15:0]  addr;
        logic         wr;
        logic [127:0] data;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    logic         sel_b = 1'b0;
    logic         cur_s_read, cur_s_write;
    logic [15:0]  cur_s_address;
    logic [127:0] cur_s_wdata;
    logic [3:0]   cur_m_resp;

    assign cur_s_read    = sel_b ? b_s_read    : a_s_read;
    assign cur_s_write   = sel_b ? b_s_write   : a_s_write;
    assign cur_s_address = sel_b ? b_s_address : a_s_address;
    assign cur_s_wdata   = sel_b ? b_s_wdata   : a_s_wdata;
    assign cur_m_resp    = sel_b ? b_m_resp    : {2'b00, a_m_resp};

    task automatic push(input int ch, input logic [15:0] addr, input logic wr,
                        input logic [127:0] data);
        exp_t e;
        e.ch = ch; e.addr = addr; e.wr = wr; e.data = data;
        sb.push_back(e);
    endtask

    // Waits for the next downstream request, checks it against the scoreboard
    // head, responds after 'delay' cycles and checks completion and the gap.
    task automatic serve(input bit use_b, input int delay, input bit keep,
                         output int waited);
        exp_t         e;
        bit           found;
        logic [127:0] pat;
        logic [15:0]  addr0;
        waited = 0;
        found  = 0;
        sel_b  = use_b;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL serve_sb_empty: got empty scoreboard, need an entry");
            return;
        end
        e = sb.pop_front();
        #1;
        while (!found && waited < 50) begin
            if (cur_s_read || cur_s_write) found = 1;
            else begin
                @(posedge clk); #2;
                waited++;
            end
        end
        if (!found) begin
            errors++;
            $display("FAIL serve_timeout ch%0d: got no request in %0d cycles, need one", e.ch, waited);
            return;
        end
        checks += 3;
        if (cur_s_write !== e.wr) begin
            errors++;
            $display("FAIL s_write ch%0d: got %b need %b", e.ch, cur_s_write, e.wr);
        end
        if (cur_s_read !== !e.wr) begin
            errors++;
            $display("FAIL s_read ch%0d: got %b need %b", e.ch, cur_s_read, !e.wr);
        end
        if (cur_s_address !== e.addr) begin
            errors++;
            $display("FAIL s_address ch%0d: got %h need %h", e.ch, cur_s_address, e.addr);
        end
        if (e.wr) begin
            checks++;
            if (cur_s_wdata !== e.data) begin
                errors++;
                $display("FAIL s_wdata ch%0d: got %h need %h", e.ch, cur_s_wdata, e.data);
            end
        end
        addr0 = cur_s_address;
        repeat (delay) begin
            @(posedge clk); #2;
            checks++;
            if (cur_s_address !== addr0 || !(cur_s_read || cur_s_write)) begin
                errors++;
                $display("FAIL busy_hold ch%0d: got addr %h req %b, need addr %h req 1",
                         e.ch, cur_s_address, cur_s_read | cur_s_write, addr0);
            end
        end
        pat = {$urandom, $urandom, $urandom, $urandom};
        if (use_b) begin b_s_resp = 1'b1; b_s_rdata = pat; end
        else       begin a_s_resp = 1'b1; a_s_rdata = pat; end
        #1;
        checks += 2;
        if (cur_m_resp !== 4'(1 << e.ch)) begin
            errors++;
            $display("FAIL m_resp ch%0d: got %b need %b", e.ch, cur_m_resp, 4'(1 << e.ch));
        end
        if (use_b ? (b_m_rdata !== {4{pat}}) : (a_m_rdata !== {2{pat}})) begin
            errors++;
            $display("FAIL m_rdata ch%0d: lanes do not all carry %h", e.ch, pat);
        end
        @(posedge clk); #1;
        if (use_b) begin
            b_s_resp = 1'b0;
            if (!keep) begin b_m_read[e.ch] = 1'b0; b_m_write[e.ch] = 1'b0; end
        end else begin
            a_s_resp = 1'b0;
            if (!keep) begin a_m_read[e.ch] = 1'b0; a_m_write[e.ch] = 1'b0; end
        end
        #1;
        checks++;
        if (cur_s_read !== 1'b0 || cur_s_write !== 1'b0 || cur_m_resp !== 4'b0) begin
            errors++;
            $display("FAIL gap ch%0d: got rd %b wr %b resp %b, need all 0",
                     e.ch, cur_s_read, cur_s_write, cur_m_resp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_m_read = '0; a_m_write = '0; a_m_address = '0; a_m_wdata = '0;
        a_s_resp = 1'b0; a_s_rdata = '0;
        b_m_read = '0; b_m_write = '0; b_m_address = '0; b_m_wdata = '0;
        b_s_resp = 1'b0; b_s_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a_s_read, a_s_write, a_m_resp, b_s_read, b_s_write, b_m_resp} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b need all 0",
                     {a_s_read, a_s_write, a_m_resp, b_s_read, b_s_write, b_m_resp});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fixed_priority();
        int w;
        a_m_address[0] = 16'h0040;
        a_m_address[1] = 16'h0080;
        a_m_read = 2'b11;
        push(0, 16'h0040, 1'b0, '0);
        push(1, 16'h0080, 1'b0, '0);
        serve(1'b0, 2, 1'b0, w);
        checks++;
        if (w !== 1) begin
            errors++;
            $display("FAIL first_latency: got %0d cycles need 1", w);
        end
        serve(1'b0, 1, 1'b0, w);
    endtask

    task automatic test_rw_collision();
        int w;
        a_m_address[1] = 16'h0300;
        a_m_wdata[1]   = {4{32'hDEAD_BEEF}};
        a_m_read[1]    = 1'b1;
        a_m_write[1]   = 1'b1;
        push(1, 16'h0300, 1'b1, {4{32'hDEAD_BEEF}});
        serve(1'b0, 0, 1'b0, w);
    endtask

    task automatic test_round_robin();
        int w;
        for (int i = 0; i < 4; i++) b_m_address[i] = 16'h1000 + 16'(i * 16);
        b_m_read = 4'b1111;
        for (int t = 0; t < 8; t++) push(t % 4, 16'h1000 + 16'((t % 4) * 16), 1'b0, '0);
        for (int t = 0; t < 8; t++) serve(1'b1, t % 3, 1'b1, w);
        b_m_read = 4'b0000;
    endtask

    task automatic test_write();
        int w;
        b_m_address[2] = 16'h1230;
        b_m_wdata[2]   = {16{8'hA5}};
        b_m_write[2]   = 1'b1;
        push(2, 16'h1230, 1'b1, {16{8'hA5}});
        serve(1'b1, 1, 1'b0, w);
    endtask

    task automatic test_reset_abort();
        int w;
        @(posedge clk); #1;
        b_m_address[1] = 16'h2220;
        b_m_read[1]    = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (b_s_read !== 1'b1 || b_s_address !== 16'h2220) begin
            errors++;
            $display("FAIL abort_busy: got rd %b addr %h need 1 2220", b_s_read, b_s_address);
        end
        rst_n    = 1'b0;
        b_s_resp = 1'b1;
        #1;
        checks++;
        if ({b_s_read, b_s_write, b_m_resp} !== 6'b0 || b_s_address !== 16'h0 || b_s_wdata !== '0) begin
            errors++;
            $display("FAIL abort_outputs: got rd %b wr %b resp %b addr %h, need all 0",
                     b_s_read, b_s_write, b_m_resp, b_s_address);
        end
        b_s_resp = 1'b0;
        b_m_read = 4'b1001;
        b_m_address[0] = 16'h3000;
        b_m_address[3] = 16'h3300;
        push(0, 16'h3000, 1'b0, '0);
        push(3, 16'h3300, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        serve(1'b1, 0, 1'b0, w);
        serve(1'b1, 0, 1'b0, w);
    endtask

    task automatic test_long_resp();
        int w;
        @(posedge clk); #1;
        a_m_address[0] = 16'h0040;
        a_m_address[1] = 16'h0080;
        a_m_read = 2'b11;
        push(0, 16'h0040, 1'b0, '0);
        push(1, 16'h0080, 1'b0, '0);
        serve(1'b0, 10, 1'b0, w);
        serve(1'b0, 0, 1'b0, w);
        checks++;
        if (w !== 2) begin
            errors++;
            $display("FAIL back_to_back_gap: got %0d cycles need 2", w);
        end
    endtask

    initial begin
        test_reset();
        test_fixed_priority();
        test_rw_collision();
        test_round_robin();
        test_write();
        test_reset_abort();
        test_long_resp();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d leftover entries need 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end
endmodule
